cms_axis_receiver: RTL and testbench
====================================

CMS_AXIS_RECEIVER -- requirements
Module: cms_axis_receiver

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, program-counter width.
REQ-002 The block SHALL have parameter AXI_DATA_WIDTH, default XLEN+32, stream beat width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2, receive buffer entries.
REQ-004 The block SHALL have port clk, input, 1 bit, single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-006 The block SHALL have port S_AXIS_tvalid, input, 1 bit, upstream beat valid.
REQ-007 The block SHALL have port S_AXIS_tready, output, 1 bit, beat accept.
REQ-008 The block SHALL have port S_AXIS_tdata, input, AXI_DATA_WIDTH bits: [AXI_DATA_WIDTH-1:32] = pc, [31:0] = instr.
REQ-009 The block SHALL have port S_AXIS_tlast, input, 1 bit, end-of-frame marker.
REQ-010 The block SHALL have port tlast_interval, input, 32 bits, expected beats per frame; 0 disables checking.
REQ-011 The block SHALL have port en, input, 1 bit, receive enable.
REQ-012 The block SHALL have port out_valid, output, 1 bit, unpacked item available.
REQ-013 The block SHALL have port out_ready, input, 1 bit, downstream pop.
REQ-014 The block SHALL have ports out_pc (output, XLEN bits), out_instr (output, 32 bits) and out_last (output, 1 bit), all taken from the FIFO head.
REQ-015 The block SHALL have port pkt_count, output, 32 bits, accepted beats.
REQ-016 The block SHALL have port frame_count, output, 16 bits, accepted tlast beats.
REQ-017 The block SHALL have ports tlast_err (output, 1 bit, sticky framing error) and err_clear (input, 1 bit, clears tlast_err).

Function
REQ-018 A beat SHALL be accepted iff S_AXIS_tvalid && S_AXIS_tready at a rising edge.
REQ-019 S_AXIS_tready SHALL be a register equal to en && (FIFO not full) with no pass-through; when full, a same-cycle pop does not enable a push.
REQ-020 Each accepted beat SHALL push {pc, instr, tlast} into the FIFO; out_valid SHALL assert on the cycle after the push (1-cycle latency).
REQ-021 out_valid SHALL equal FIFO not empty; a pop occurs iff out_valid && out_ready; out_* data SHALL stay stable while out_valid && !out_ready.
REQ-022 A simultaneous push and pop when the FIFO is neither full nor empty SHALL leave the occupancy unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-023 Deasserting en SHALL stop acceptance from the next cycle only; the FIFO SHALL keep draining.
REQ-024 pkt_count SHALL increment per accepted beat and saturate at 0xFFFFFFFF; frame_count SHALL increment per accepted tlast beat and wrap at 0xFFFF.
REQ-025 The checker SHALL be an FSM with states IDLE (no beat of the current frame yet) and IN_FRAME, plus a 32-bit beat index idx.
REQ-026 On an accepted beat the checker SHALL compute last_expected = (idx == tlast_interval-1).
REQ-027 If tlast_interval != 0 and S_AXIS_tlast != last_expected, the checker SHALL set tlast_err.
REQ-028 If tlast or last_expected is true, the checker SHALL set idx=0 and go to IDLE; otherwise it SHALL set idx=idx+1 and go to IN_FRAME.
REQ-029 When tlast_interval == 0, the checker SHALL report no errors and SHALL reset idx only on tlast.
REQ-030 err_clear SHALL clear tlast_err; if err_clear and a new error occur in the same cycle, set SHALL win.
REQ-031 A tlast_interval change mid-frame SHALL take effect on the next accepted beat, compared against the current idx.

Reset
REQ-032 On rst_n low at a clock edge: S_AXIS_tready=0, FIFO empty, out_valid=0, out_pc/out_instr/out_last=0, pkt_count=0, frame_count=0, tlast_err=0, idx=0, FSM=IDLE.
REQ-033 A reset mid-frame or with a non-empty FIFO SHALL discard all buffered beats; S_AXIS_tready SHALL return to en && !full on the first edge after release.

Configuration
REQ-034 With macro CMS_RX_TLAST_CHECK_EN defined, the checker FSM, idx and tlast_err logic SHALL be compiled in as specified above.
REQ-035 Without CMS_RX_TLAST_CHECK_EN, the checker, idx and FSM SHALL be absent, tlast_err SHALL be tied to 0, and err_clear SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-036 Reset release, en=1, out_ready=1, 3 beats pc=8,12,16 -> out_pc 8,12,16 each one cycle after acceptance; pkt_count=3.
REQ-037 out_ready=0, 6 back-to-back beats -> exactly 4 accepted, S_AXIS_tready=0 after the 4th; raise out_ready -> items emerge in order, 2 remaining beats accepted.
REQ-038 tlast_interval=100, tlast on beats 100 and 200 -> tlast_err=0, frame_count=2.
REQ-039 tlast_interval=4, tlast on beat 3 -> tlast_err=1; err_clear pulse -> 0; next frames of 4 -> stays 0.
REQ-040 Reset asserted with 2 items buffered mid-frame -> out_valid=0, counts 0, idx 0; next frame of tlast_interval beats -> no error.
REQ-041 Build without CMS_RX_TLAST_CHECK_EN, feed the stimulus of REQ-039 -> tlast_err stays 0, data path identical to REQ-036.

Source files
------------

// File: rtl/cms_axis_receiver.sv
// AXI-Stream receiver: unpacks {pc, instr, tlast} beats into a small FIFO, counts beats/frames.
// Optional tlast framing checker compiled in with `define CMS_RX_TLAST_CHECK_EN.
module cms_axis_receiver #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned AXI_DATA_WIDTH = XLEN + 32,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    input  logic                      en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_last,
    output logic [31:0]               pkt_count,
    output logic [15:0]               frame_count,
    output logic                      tlast_err,
    input  logic                      err_clear
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            last;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    entry_t          head;

    assign push = S_AXIS_tvalid && S_AXIS_tready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    // FIFO storage, pointers and the registered ready (no pass-through from pop)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            S_AXIS_tready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc:    XLEN'(S_AXIS_tdata[AXI_DATA_WIDTH-1:32]),
                                 instr: S_AXIS_tdata[31:0],
                                 last:  S_AXIS_tlast};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count         <= count_next;
            S_AXIS_tready <= en && (count_next != CW'(FIFO_DEPTH));
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_last  = head.last;

    // Beat counter saturates, frame counter wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count   <= '0;
            frame_count <= '0;
        end else if (push) begin
            if (pkt_count != 32'hFFFF_FFFF) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (S_AXIS_tlast) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef CMS_RX_TLAST_CHECK_EN
    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] idx;
    logic [31:0] idx_next;
    logic        err_q;
    logic        err_next;
    logic        last_expected;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            err_q <= err_next;
        end
    end

    // Interval 0 never predicts a frame end, so only tlast resets idx
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        err_next      = err_q && !err_clear;
        last_expected = 1'b0;
        if (push) begin
            last_expected = (tlast_interval != 32'd0) && (idx == tlast_interval - 32'd1);
            if ((tlast_interval != 32'd0) && (S_AXIS_tlast != last_expected)) begin
                err_next = 1'b1;
            end
            if (S_AXIS_tlast || last_expected) begin
                idx_next   = '0;
                state_next = IDLE;
            end else begin
                idx_next   = idx + 32'd1;
                state_next = IN_FRAME;
            end
        end
    end

    assign tlast_err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{err_clear, tlast_interval};
    assign tlast_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cms_axis_receiver.sv
// Scoreboard bench for cms_axis_receiver: expected items queued on handshake, checked on pop.
module tb_cms_axis_receiver;

    localparam bit CHK =
`ifdef CMS_RX_TLAST_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tready;
    logic [95:0] S_AXIS_tdata;
    logic        S_AXIS_tlast;
    logic [31:0] tlast_interval;
    logic        en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_last;
    logic [31:0] pkt_count;
    logic [15:0] frame_count;
    logic        tlast_err;
    logic        err_clear;

    cms_axis_receiver dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
        .tlast_interval(tlast_interval), .en(en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_last(out_last),
        .pkt_count(pkt_count), .frame_count(frame_count),
        .tlast_err(tlast_err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_pkt = 0;
    int   exp_frame = 0;
    bit   lat_chk = 1'b0;

    // Monitor at negedge: pops are checked against the queue, handshakes push expectations
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
            exp_pkt   = 0;
            exp_frame = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL pop_unexpected: got pc=%h, wanted no item", out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    if ({out_pc, out_instr, out_last} !== {mon_e.pc, mon_e.instr, mon_e.last}) begin
                        n_bad++;
                        $display("FAIL item: got pc=%h instr=%h last=%b, wanted pc=%h instr=%h last=%b",
                                 out_pc, out_instr, out_last, mon_e.pc, mon_e.instr, mon_e.last);
                    end
                    if (lat_chk) begin
                        n_cmp++;
                        if (cyc != mon_e.cyc + 1) begin
                            n_bad++;
                            $display("FAIL latency: got %0d cycles, wanted 1", cyc - mon_e.cyc);
                        end
                    end
                end
            end
            if (S_AXIS_tvalid && S_AXIS_tready) begin
                mon_e.pc    = S_AXIS_tdata[95:32];
                mon_e.instr = S_AXIS_tdata[31:0];
                mon_e.last  = S_AXIS_tlast;
                mon_e.cyc   = cyc;
                sb.push_back(mon_e);
                exp_pkt++;
                if (S_AXIS_tlast) exp_frame++;
            end
        end
    end

    task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic last);
        int t = 0;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = {pc, ins};
        S_AXIS_tlast  = last;
        @(negedge clk);
        while (!S_AXIS_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got tready=0 for %0d cycles, wanted accept", t);
        end
        @(posedge clk); #1;
        S_AXIS_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d items pending, wanted 0", sb.size());
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 8;
        if (S_AXIS_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b, wanted 0", S_AXIS_tready); end
        if (out_valid !== 1'b0)     begin n_bad++; $display("FAIL rst_out_valid: got %b, wanted 0", out_valid); end
        if (out_pc !== 64'h0)       begin n_bad++; $display("FAIL rst_out_pc: got %h, wanted 0", out_pc); end
        if (out_instr !== 32'h0)    begin n_bad++; $display("FAIL rst_out_instr: got %h, wanted 0", out_instr); end
        if (out_last !== 1'b0)      begin n_bad++; $display("FAIL rst_out_last: got %b, wanted 0", out_last); end
        if (pkt_count !== 32'h0)    begin n_bad++; $display("FAIL rst_pkt_count: got %0d, wanted 0", pkt_count); end
        if (frame_count !== 16'h0)  begin n_bad++; $display("FAIL rst_frame_count: got %0d, wanted 0", frame_count); end
        if (tlast_err !== 1'b0)     begin n_bad++; $display("FAIL rst_tlast_err: got %b, wanted 0", tlast_err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (S_AXIS_tready !== 1'b1) begin n_bad++; $display("FAIL release_tready: got %b, wanted 1", S_AXIS_tready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        send(64'd8,  32'h0000_0013, 1'b0);
        send(64'd12, 32'h0000_0093, 1'b0);
        send(64'd16, 32'h0000_0113, 1'b1);
        wait_drain();
        lat_chk = 1'b0;
        n_cmp += 2;
        if (pkt_count !== 32'd3)   begin n_bad++; $display("FAIL basic_pkt_count: got %0d, wanted 3", pkt_count); end
        if (frame_count !== 16'd1) begin n_bad++; $display("FAIL basic_frame_count: got %0d, wanted 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int t = 0;
        out_ready     = 1'b0;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = {64'h100, 32'hA0};
        S_AXIS_tlast  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (S_AXIS_tready && S_AXIS_tvalid) acc++;
            @(posedge clk); #1;
            S_AXIS_tdata = {64'h100 + 64'(4 * acc), 32'hA0 + 32'(acc)};
            S_AXIS_tlast = (acc == 5);
        end
        n_cmp += 4;
        if (acc != 4)               begin n_bad++; $display("FAIL full_accepted: got %0d, wanted 4", acc); end
        if (S_AXIS_tready !== 1'b0) begin n_bad++; $display("FAIL full_tready: got %b, wanted 0", S_AXIS_tready); end
        if (out_valid !== 1'b1)     begin n_bad++; $display("FAIL full_out_valid: got %b, wanted 1", out_valid); end
        if (out_pc !== 64'h100)     begin n_bad++; $display("FAIL stall_head_pc: got %h, wanted 100", out_pc); end
        out_ready = 1'b1;
        while (acc < 6 && t < 50) begin
            @(negedge clk);
            if (S_AXIS_tready && S_AXIS_tvalid) acc++;
            @(posedge clk); #1;
            S_AXIS_tdata = {64'h100 + 64'(4 * acc), 32'hA0 + 32'(acc)};
            S_AXIS_tlast = (acc == 5);
            t++;
        end
        S_AXIS_tvalid = 1'b0;
        wait_drain();
        n_cmp += 2;
        if (acc != 6)              begin n_bad++; $display("FAIL resume_accepted: got %0d, wanted 6", acc); end
        if (pkt_count !== 32'd9)   begin n_bad++; $display("FAIL resume_pkt_count: got %0d, wanted 9", pkt_count); end
    endtask

    task automatic test_en();
        out_ready = 1'b0;
        send(64'h200, 32'h1, 1'b0);
        send(64'h204, 32'h2, 1'b1);
        en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (S_AXIS_tready !== 1'b1) begin n_bad++; $display("FAIL en_same_cycle: got %b, wanted 1", S_AXIS_tready); end
        @(posedge clk); #1;
        n_cmp++;
        if (S_AXIS_tready !== 1'b0) begin n_bad++; $display("FAIL en_off_tready: got %b, wanted 0", S_AXIS_tready); end
        out_ready = 1'b1;
        wait_drain();
        en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (S_AXIS_tready !== 1'b1) begin n_bad++; $display("FAIL en_on_tready: got %b, wanted 1", S_AXIS_tready); end
    endtask

    task automatic test_tlast_ok();
        apply_reset();
        tlast_interval = 32'd100;
        out_ready      = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(64'h1000 + 64'(4 * i), 32'(i), (i == 99) || (i == 199));
        end
        wait_drain();
        n_cmp += 3;
        if (tlast_err !== 1'b0)      begin n_bad++; $display("FAIL ok_tlast_err: got %b, wanted 0", tlast_err); end
        if (frame_count !== 16'd2)   begin n_bad++; $display("FAIL ok_frame_count: got %0d, wanted 2", frame_count); end
        if (pkt_count !== 32'd200)   begin n_bad++; $display("FAIL ok_pkt_count: got %0d, wanted 200", pkt_count); end
    endtask

    task automatic test_tlast_err();
        apply_reset();
        tlast_interval = 32'd4;
        out_ready      = 1'b1;
        for (int i = 0; i < 3; i++) send(64'h2000 + 64'(4 * i), 32'(i), i == 2);
        n_cmp++;
        if (tlast_err !== CHK) begin n_bad++; $display("FAIL early_tlast: got %b, wanted %b", tlast_err, CHK); end
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        n_cmp++;
        if (tlast_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b, wanted 0", tlast_err); end
        for (int i = 0; i < 8; i++) send(64'h3000 + 64'(4 * i), 32'(i), (i % 4) == 3);
        n_cmp++;
        if (tlast_err !== 1'b0) begin n_bad++; $display("FAIL good_frames: got %b, wanted 0", tlast_err); end
        err_clear = 1'b1;
        send(64'h4000, 32'h5, 1'b1);
        err_clear = 1'b0;
        n_cmp++;
        if (tlast_err !== CHK) begin n_bad++; $display("FAIL set_wins: got %b, wanted %b", tlast_err, CHK); end
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        send(64'h5000, 32'h6, 1'b0);
        send(64'h5004, 32'h7, 1'b0);
        tlast_interval = 32'd3;
        send(64'h5008, 32'h8, 1'b1);
        n_cmp++;
        if (tlast_err !== 1'b0) begin n_bad++; $display("FAIL interval_change: got %b, wanted 0", tlast_err); end
        send(64'h6000, 32'h9, 1'b0);
        send(64'h6004, 32'hA, 1'b0);
        send(64'h6008, 32'hB, 1'b0);
        n_cmp++;
        if (tlast_err !== CHK) begin n_bad++; $display("FAIL missing_tlast: got %b, wanted %b", tlast_err, CHK); end
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear      = 1'b0;
        tlast_interval = 32'd0;
        for (int i = 0; i < 7; i++) send(64'h7000 + 64'(4 * i), 32'(i), (i == 1) || (i == 6));
        wait_drain();
        n_cmp += 3;
        if (tlast_err !== 1'b0)            begin n_bad++; $display("FAIL interval_zero: got %b, wanted 0", tlast_err); end
        if (frame_count !== 16'(exp_frame)) begin n_bad++; $display("FAIL err_frame_count: got %0d, wanted %0d", frame_count, exp_frame); end
        if (pkt_count !== 32'(exp_pkt))     begin n_bad++; $display("FAIL err_pkt_count: got %0d, wanted %0d", pkt_count, exp_pkt); end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        tlast_interval = 32'd4;
        out_ready      = 1'b0;
        send(64'h8000, 32'h1, 1'b0);
        send(64'h8004, 32'h2, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_buffered: got %b, wanted 1", out_valid); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp += 4;
        if (out_valid !== 1'b0)     begin n_bad++; $display("FAIL mid_rst_valid: got %b, wanted 0", out_valid); end
        if (pkt_count !== 32'd0)    begin n_bad++; $display("FAIL mid_rst_pkt: got %0d, wanted 0", pkt_count); end
        if (frame_count !== 16'd0)  begin n_bad++; $display("FAIL mid_rst_frame: got %0d, wanted 0", frame_count); end
        if (S_AXIS_tready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tready: got %b, wanted 0", S_AXIS_tready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(64'h9000 + 64'(4 * i), 32'(i), i == 3);
        wait_drain();
        n_cmp += 3;
        if (tlast_err !== 1'b0)    begin n_bad++; $display("FAIL post_rst_err: got %b, wanted 0", tlast_err); end
        if (frame_count !== 16'd1) begin n_bad++; $display("FAIL post_rst_frame: got %0d, wanted 1", frame_count); end
        if (pkt_count !== 32'd4)   begin n_bad++; $display("FAIL post_rst_pkt: got %0d, wanted 4", pkt_count); end
    endtask

    initial begin
        rst_n          = 1'b0;
        en             = 1'b1;
        S_AXIS_tvalid  = 1'b0;
        S_AXIS_tdata   = '0;
        S_AXIS_tlast   = 1'b0;
        tlast_interval = 32'd0;
        out_ready      = 1'b0;
        err_clear      = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_en();
        test_tlast_ok();
        test_tlast_err();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, wanted completion");
        $fatal(1);
    end

endmodule
